// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the 160-bit ID/EX pipeline word, used by the ID/EX
// writer and by the EX-stage decoder.
package id_ex_stage_reg_pkg;

  localparam logic [5:0] SPECIAL = 6'b000000;
  localparam logic [5:0] BEQ     = 6'b000100;
  localparam logic [5:0] BNE     = 6'b000101;
  localparam logic [5:0] ANDI    = 6'b001100;
  localparam logic [5:0] ORI     = 6'b001101;
  localparam logic [5:0] XORI    = 6'b001110;
  localparam logic [5:0] LB      = 6'b100000;
  localparam logic [5:0] LW      = 6'b100011;
  localparam logic [5:0] LBU     = 6'b100100;
  localparam logic [5:0] SB      = 6'b101000;
  localparam logic [5:0] SW      = 6'b101011;

  localparam int IDEX_W    = 160;
  localparam int INSTR_LSB = 0;
  localparam int INSTR_MSB = 31;
  localparam int PC4_LSB   = 32;
  localparam int PC4_MSB   = 63;
  localparam int RS_LSB    = 64;
  localparam int RS_MSB    = 95;
  localparam int RT_LSB    = 96;
  localparam int RT_MSB    = 127;
  localparam int IMM_LSB   = 128;
  localparam int IMM_MSB   = 159;

  localparam logic [IDEX_W-1:0] BUBBLE_WORD = {128'h0, 32'h0000_0000};

  // Bubble word for a pipeline built with a non-default NOP encoding.
  function automatic logic [IDEX_W-1:0] bubble_word(input logic [31:0] nop);
    return {128'h0, nop};
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Combinational load-use detector: compares the load sitting in EX against the
// source registers of the instruction in ID.
module hazard_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic       ex_valid,
  input  logic [5:0] ex_op,
  input  logic [4:0] ex_rt,
  input  logic [5:0] id_op,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use,
  output logic       uses_rt
);

  logic ex_load;

  assign ex_load = ex_valid & ((ex_op == LW) | (ex_op == LB) | (ex_op == LBU));

  // rt is a source only for R-type, branches and stores; elsewhere it is a destination.
  assign uses_rt = (id_op == SPECIAL) | (id_op == BEQ) | (id_op == BNE) |
                   (id_op == SW) | (id_op == SB);

  assign load_use = ex_load & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register writer: packs instruction, operands and extended
// immediate, inserts load-use bubbles, honours stall/flush, counts stalls.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc4,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_waddr,
  input  logic [31:0]       wb_wdata,
  output logic [IDEX_W-1:0] idex_reg,
  output logic              idex_valid,
  output logic              stall_up,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] ext_imm(input logic [31:0] instr);
    logic signed [15:0] imm16;
    logic signed [31:0] imm_sx;
    imm16  = instr[15:0];
    imm_sx = imm16;
    if ((instr[31:26] == ANDI) || (instr[31:26] == ORI) || (instr[31:26] == XORI))
      return {16'h0, instr[15:0]};
    return imm_sx;
  endfunction

  logic              load_use;
  logic              uses_rt_unused;
  logic [31:0]       rs_val_p0;
  logic [31:0]       rt_val_p0;
  logic [IDEX_W-1:0] cap_word_p0;
  logic [IDEX_W-1:0] bubble_p0;

  // uses_rt is also consumed by the forwarding unit; unused at this level.
  hazard_detect u_hazard (
    .ex_valid (idex_valid),
    .ex_op    (idex_reg[INSTR_LSB+31:INSTR_LSB+26]),
    .ex_rt    (idex_reg[INSTR_LSB+20:INSTR_LSB+16]),
    .id_op    (id_instr[31:26]),
    .id_rs    (id_instr[25:21]),
    .id_rt    (id_instr[20:16]),
    .load_use (load_use),
    .uses_rt  (uses_rt_unused)
  );

  assign stall_up = ex_stall | (load_use & ~flush);

  assign rs_val_p0 = (wb_we && (wb_waddr != 5'd0) && (wb_waddr == id_instr[25:21]))
                     ? wb_wdata : id_rs_data;
  assign rt_val_p0 = (wb_we && (wb_waddr != 5'd0) && (wb_waddr == id_instr[20:16]))
                     ? wb_wdata : id_rt_data;

  assign cap_word_p0 = {ext_imm(id_instr), rt_val_p0, rs_val_p0, id_pc4, id_instr};
  assign bubble_p0   = bubble_word(NOP_WORD);

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_reg   <= bubble_p0;
      idex_valid <= 1'b0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (ex_stall)
        stall_cnt <= sat_inc(stall_cnt);
      if (flush) begin
        idex_reg   <= bubble_p0;
        idex_valid <= 1'b0;
      end else if (ex_stall) begin
        idex_reg   <= idex_reg;
        idex_valid <= idex_valid;
      end else if (load_use) begin
        idex_reg   <= bubble_p0;
        idex_valid <= 1'b0;
        bubble_cnt <= sat_inc(bubble_cnt);
      end else begin
        idex_reg   <= cap_word_p0;
        idex_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Writer side of the 160-bit ID/EX pipeline word. The downstream EX-stage decoder reads this word to derive the ALU operation, the overflow check and the CP0 path.
- Captures ID-stage instruction and operand data every cycle and packs them into the fixed layout. It also resolves a write-back same-cycle bypass and extends the immediate.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and flush requests.
- Sits between the register-file read in ID and the EX stage. Also keeps saturating stall and bubble performance counters.

Parameters:
- NOP_WORD, 32'h0000_0000, instruction word inserted on bubble or flush (sll $0,$0,0).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- id_instr  input  32  instruction in ID.
- id_pc4  input  32  PC+4 of that instruction.
- id_rs_data  input  32  register-file read data for rs.
- id_rt_data  input  32  register-file read data for rt.
- ex_stall  input  1  downstream (EX/MEM) cannot accept; hold the register.
- flush  input  1  squash the ID/EX contents (branch taken or exception).
- wb_we  input  1  write-back write enable, same cycle.
- wb_waddr  input  5  write-back destination register.
- wb_wdata  input  32  write-back data.
- idex_reg  output  160  packed word: [31:0] instr, [63:32] pc4, [95:64] rs value, [127:96] rt value, [159:128] extended immediate.
- idex_valid  output  1  the word holds a real instruction (0 means bubble).
- stall_up  output  1  combinational; hold PC and IF/ID this cycle.
- stall_cnt  output  CNT_W  cycles with ex_stall=1, saturating.
- bubble_cnt  output  CNT_W  load-use bubbles inserted, saturating.

Behaviour:
- Reset state:
  - idex_reg = {32'h0, 32'h0, 32'h0, 32'h0, NOP_WORD}.
  - idex_valid = 0, stall_cnt = 0, bubble_cnt = 0.
  - stall_up follows its combinational equation.
- Load-use detection (combinational):
  - ex_load is true when idex_valid=1 and idex_reg[31:26] is one of 100011, 100000, 100100.
  - ex_rt = idex_reg[20:16]. ex_rt=0 never counts as a hazard.
  - uses_rt is true for id_instr op 000000, 000100, 000101, 101011, 101000.
  - load_use = ex_load & ex_rt!=0 & (ex_rt==id_instr[25:21] | (uses_rt & ex_rt==id_instr[20:16])).
- stall_up = ex_stall | (load_use & ~flush).
- Per-edge update, highest priority first:
  1. rst: load the reset state.
  2. flush: idex_reg <= bubble word (NOP_WORD, all other fields 0); idex_valid <= 0. Flush overrides ex_stall.
  3. ex_stall: hold idex_reg and idex_valid unchanged. No bubble is inserted even if load_use is true.
  4. load_use: insert the bubble word, idex_valid <= 0, bubble_cnt += 1.
  5. Otherwise capture: instr = id_instr, pc4 = id_pc4, rs/rt values after bypass, imm per the extension rule; idex_valid <= 1.
- Write-back bypass (applies on capture only):
  - If wb_we & wb_waddr!=0 & wb_waddr==id_instr[25:21], the rs field takes wb_wdata instead of id_rs_data.
  - Same rule for rt against id_instr[20:16].
  - Both fields may bypass in the same cycle.
- Immediate extension:
  - op 001100, 001101, 001110: zero-extend id_instr[15:0].
  - All other ops: sign-extend id_instr[15:0].
  - R-type captures the extension too (value unused downstream).
- Counters:
  - stall_cnt increments on every non-reset edge with ex_stall=1, including an edge where flush is also 1.
  - Both counters stop at all-ones and do not wrap.
- Latency: one cycle from ID inputs to idex_reg. stall_up has zero latency.
- Reset asserted mid-stall or mid-bubble: everything is cleared on that edge; no residual hazard remains.

Decomposition:
- Shared package, also used by the EX-stage decoder:
  - Opcode constants: LW, LB, LBU, SW, SB, BEQ, BNE, SPECIAL, ANDI, ORI, XORI.
  - Field-slice localparams for the 160-bit word: instr, pc4, rs, rt, imm.
  - The bubble-word constant.
- One sub-module, hazard_detect: purely combinational, produces load_use and uses_rt. It is reused by the forwarding logic.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then release with id_instr=0.
  - Required response: idex_reg=160'h0, idex_valid=0 while reset; stall_up=0; both counters 0.
- Capture with immediate extension:
  - Stimulus: id_instr=0x2009FFFF (addi), id_pc4=0x404.
  - Required response: next cycle imm field=0xFFFFFFFF, pc4=0x404, idex_valid=1.
  - Repeat with 0x3409FFFF (ori): required imm=0x0000FFFF.
- Load-use bubble:
  - Stimulus: EX holds 0x8C090000 (lw $9). ID presents 0x01295020 (add $10,$9,$9).
  - Required response: stall_up=1 that cycle; next cycle the bubble word with idex_valid=0 and bubble_cnt=1.
  - The following cycle the add is captured.
  - Repeat with lw $0: required stall_up=0.
- Write-back bypass:
  - Stimulus: wb_we=1, wb_waddr=9, wb_wdata=0xDEADBEEF, id_rs_data=0x1, instr rs=rt=9.
  - Required response: rs and rt fields both read 0xDEADBEEF.
  - With wb_waddr=0: required fields hold the register-file data unchanged.
- Stall versus flush:
  - Stimulus: hold ex_stall=1 for 3 cycles.
  - Required response: idex_reg frozen and stall_cnt=3.
  - Then flush=1 together with ex_stall=1: required bubble word loaded and stall_cnt=4.
- Counter saturation:
  - Stimulus: ex_stall high for 2^CNT_W+5 cycles.
  - Required response: stall_cnt stays at 16'hFFFF.
